// File: rtl/reset_sequencer.sv
// Staggered reset release sequencer: holds N reset domains, releases them in index order,
// waits for core ready with a timeout, then gates GPI through and counts run cycles.
module reset_sequencer #(
    parameter int NUM_RESETS     = 4,
    parameter int HOLD_CYCLES    = 5,
    parameter int STAGGER_CYCLES = 2,
    parameter int READY_TIMEOUT  = 1000,
    parameter int CNT_WIDTH      = 16,
    parameter int GPI_WIDTH      = 32
) (
    input  logic                  XCLK,
    input  logic                  XRESET,
    input  logic                  start,
    input  logic                  ready,
    input  logic [GPI_WIDTH-1:0]  gpi_in,
    output logic [NUM_RESETS-1:0] rst_out,
    output logic [GPI_WIDTH-1:0]  gpi_out,
    output logic [2:0]            state,
    output logic                  done,
    output logic                  fault,
    output logic                  fault_cause,
    output logic [CNT_WIDTH-1:0]  cycle_count
);

    typedef enum logic [2:0] {
        ST_HOLD    = 3'd0,
        ST_RELEASE = 3'd1,
        ST_WAIT    = 3'd2,
        ST_RUN     = 3'd3,
        ST_FAULT   = 3'd4
    } state_e;

    localparam logic [CNT_WIDTH-1:0] HOLD_LAST    = CNT_WIDTH'(HOLD_CYCLES - 1);
    localparam logic [CNT_WIDTH-1:0] STAGGER_LAST = CNT_WIDTH'(STAGGER_CYCLES - 1);
    localparam logic [CNT_WIDTH-1:0] TIMEOUT_LAST = CNT_WIDTH'(READY_TIMEOUT - 1);
    localparam logic [CNT_WIDTH-1:0] CNT_MAX      = '1;
    localparam logic [CNT_WIDTH-1:0] CNT_ONE      = CNT_WIDTH'(1);

    state_e                  state_q, state_d;
    logic [CNT_WIDTH-1:0]    cnt_q, cnt_d;
    logic [CNT_WIDTH-1:0]    ccnt_q, ccnt_d;
    logic [NUM_RESETS-1:0]   rst_q, rst_d, rst_shift;
    logic [GPI_WIDTH-1:0]    gpi_q, gpi_d;
    logic                    done_q, done_d;
    logic                    fault_q, fault_d;
    logic                    cause_q, cause_d;
    logic                    restart;

    // Releasing bit i next is a left shift: low bits clear first, zero means all released.
    assign rst_shift = rst_q << 1;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        ccnt_d  = ccnt_q;
        rst_d   = rst_q;
        done_d  = done_q;
        fault_d = fault_q;
        cause_d = cause_q;
        restart = 1'b0;
        gpi_d   = (state_q == ST_RUN) ? gpi_in : '0;

        case (state_q)
            ST_HOLD: begin
                if (cnt_q == HOLD_LAST) begin
                    rst_d   = rst_shift;
                    cnt_d   = '0;
                    state_d = (rst_shift == '0) ? ST_WAIT : ST_RELEASE;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            ST_RELEASE: begin
                if (cnt_q == STAGGER_LAST) begin
                    rst_d = rst_shift;
                    cnt_d = '0;
                    if (rst_shift == '0) state_d = ST_WAIT;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            ST_WAIT: begin
                // ready on the timeout sample still counts as success
                if (ready) begin
                    state_d = ST_RUN;
                    done_d  = 1'b1;
                    cnt_d   = '0;
                end else if (cnt_q == TIMEOUT_LAST) begin
                    state_d = ST_FAULT;
                    fault_d = 1'b1;
                    cause_d = 1'b0;
                    rst_d   = '1;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            ST_RUN: begin
                if (start) begin
                    restart = 1'b1;
                end else if (!ready) begin
                    state_d = ST_FAULT;
                    done_d  = 1'b0;
                    fault_d = 1'b1;
                    cause_d = 1'b1;
                    rst_d   = '1;
                end else if (ccnt_q != CNT_MAX) begin
                    ccnt_d = ccnt_q + CNT_ONE;
                end
            end
            ST_FAULT: begin
                if (start) restart = 1'b1;
            end
            default: restart = 1'b1;
        endcase

        if (restart) begin
            state_d = ST_HOLD;
            cnt_d   = '0;
            ccnt_d  = '0;
            rst_d   = '1;
            done_d  = 1'b0;
            fault_d = 1'b0;
            cause_d = 1'b0;
        end
    end

    always_ff @(posedge XCLK) begin
        if (XRESET) begin
            state_q <= ST_HOLD;
            cnt_q   <= '0;
            ccnt_q  <= '0;
            rst_q   <= '1;
            gpi_q   <= '0;
            done_q  <= 1'b0;
            fault_q <= 1'b0;
            cause_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ccnt_q  <= ccnt_d;
            rst_q   <= rst_d;
            gpi_q   <= gpi_d;
            done_q  <= done_d;
            fault_q <= fault_d;
            cause_q <= cause_d;
        end
    end

    assign rst_out     = rst_q;
    assign gpi_out     = gpi_q;
    assign state       = state_q;
    assign done        = done_q;
    assign fault       = fault_q;
    assign fault_cause = cause_q;
    assign cycle_count = ccnt_q;

endmodule

// File: tb/tb_reset_sequencer.sv
// Scoreboard bench for reset_sequencer: an edge-numbered reference model queues the expected
// outputs per edge; a monitor compares them against the DUT just after each rising edge.
module tb_reset_sequencer;

    localparam int N  = 4;
    localparam int H  = 5;
    localparam int S  = 2;
    localparam int T  = 8;
    localparam int CW = 4;
    localparam int GW = 32;

    localparam int P_HOLD = 0, P_REL = 1, P_WAIT = 2, P_RUN = 3, P_FAULT = 4;

    logic          XCLK = 1'b0;
    logic          XRESET, start, ready;
    logic [GW-1:0] gpi_in;
    logic [N-1:0]  rst_out;
    logic [GW-1:0] gpi_out;
    logic [2:0]    state;
    logic          done, fault, fault_cause;
    logic [CW-1:0] cycle_count;

    reset_sequencer #(
        .NUM_RESETS(N), .HOLD_CYCLES(H), .STAGGER_CYCLES(S),
        .READY_TIMEOUT(T), .CNT_WIDTH(CW), .GPI_WIDTH(GW)
    ) dut (
        .XCLK(XCLK), .XRESET(XRESET), .start(start), .ready(ready), .gpi_in(gpi_in),
        .rst_out(rst_out), .gpi_out(gpi_out), .state(state), .done(done),
        .fault(fault), .fault_cause(fault_cause), .cycle_count(cycle_count)
    );

    always #5 XCLK = ~XCLK;

    typedef struct packed {
        logic [2:0]    st;
        logic [N-1:0]  rst;
        logic [GW-1:0] gpi;
        logic          dn;
        logic          flt;
        logic          cause;
        logic [CW-1:0] cc;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;

    // Reference model: sequence position as an edge number since sequence start.
    int m_phase = P_HOLD;
    int m_e     = 0;
    int m_k     = 0;
    int m_cc    = 0;
    int m_cause = 0;

    task automatic model_step(input logic xr, input logic st, input logic rd, input logic [GW-1:0] g);
        exp_t x;
        logic [GW-1:0] ngpi;
        ngpi = (!xr && m_phase == P_RUN) ? g : '0;
        if (xr) begin
            m_phase = P_HOLD; m_e = 0; m_k = 0; m_cc = 0; m_cause = 0;
        end else begin
            case (m_phase)
                P_HOLD, P_REL: begin
                    m_e++;
                    if (m_e >= H + (N - 1) * S) begin m_phase = P_WAIT; m_k = 0; end
                    else if (m_e >= H) m_phase = P_REL;
                end
                P_WAIT: begin
                    m_k++;
                    if (rd) m_phase = P_RUN;
                    else if (m_k == T) begin m_phase = P_FAULT; m_cause = 0; end
                end
                P_RUN: begin
                    if (st) begin m_phase = P_HOLD; m_e = 0; m_cc = 0; m_cause = 0; end
                    else if (!rd) begin m_phase = P_FAULT; m_cause = 1; end
                    else if (m_cc < (1 << CW) - 1) m_cc++;
                end
                default: begin
                    if (st) begin m_phase = P_HOLD; m_e = 0; m_cc = 0; m_cause = 0; end
                end
            endcase
        end
        x.st = 3'(m_phase);
        for (int i = 0; i < N; i++) begin
            if (m_phase == P_HOLD || m_phase == P_REL) x.rst[i] = (m_e < H + i * S);
            else x.rst[i] = (m_phase == P_FAULT);
        end
        x.gpi   = ngpi;
        x.dn    = (m_phase == P_RUN);
        x.flt   = (m_phase == P_FAULT);
        x.cause = m_cause[0];
        x.cc    = CW'(m_cc);
        q.push_back(x);
    endtask

    // Drive one edge worth of inputs (called just after a falling edge) and queue expectations.
    task automatic cyc(input logic xr, input logic st, input logic rd, input logic [GW-1:0] g);
        XRESET = xr; start = st; ready = rd; gpi_in = g;
        model_step(xr, st, rd, g);
        @(negedge XCLK);
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    always @(posedge XCLK) begin
        exp_t e;
        #1;
        if (q.size() > 0) begin
            e = q.pop_front();
            chk("state", 64'(state), 64'(e.st));
            chk("rst_out", 64'(rst_out), 64'(e.rst));
            chk("gpi_out", 64'(gpi_out), 64'(e.gpi));
            chk("done", 64'(done), 64'(e.dn));
            chk("fault", 64'(fault), 64'(e.flt));
            if (e.flt) chk("fault_cause", 64'(fault_cause), 64'(e.cause));
            else chk("cycle_count", 64'(cycle_count), 64'(e.cc));
        end
    end

    initial begin
        XRESET = 1'b1; start = 1'b0; ready = 1'b0; gpi_in = '0;

        // Reset, ready tied high: staggered release then RUN; GPI gated until RUN.
        repeat (5) cyc(1'b1, 1'b0, 1'b1, $urandom);
        repeat (20) cyc(1'b0, 1'b0, 1'b1, 32'hA5A5_0F0F);
        // Drop ready in RUN -> fault cause 1, then restart.
        cyc(1'b0, 1'b0, 1'b0, 32'hA5A5_0F0F);
        repeat (3) cyc(1'b0, 1'b0, 1'b1, $urandom);
        cyc(1'b0, 1'b1, 1'b1, $urandom);
        // ready never arrives -> timeout fault, then restart from FAULT.
        repeat (25) cyc(1'b0, 1'b0, 1'b0, $urandom);
        cyc(1'b0, 1'b1, 1'b0, $urandom);
        // start during RELEASE is ignored; start with ready low in RUN restarts.
        for (int i = 1; i <= 16; i++) cyc(1'b0, (i == 8), 1'b1, $urandom);
        cyc(1'b0, 1'b1, 1'b0, $urandom);
        // XRESET pulse mid-RELEASE restarts numbering.
        for (int i = 1; i <= 7; i++) cyc(1'b0, 1'b0, 1'b1, $urandom);
        cyc(1'b1, 1'b0, 1'b1, $urandom);
        // Long RUN: cycle_count saturates at 15.
        repeat (40) cyc(1'b0, 1'b0, 1'b1, $urandom);

        // Randomised blocks with varying ready behaviour.
        for (int b = 0; b < 50; b++) begin
            int mode;
            mode = $urandom_range(0, 3);
            for (int c = 0; c < 40; c++) begin
                logic rd, st, xr;
                case (mode)
                    0: rd = 1'b1;
                    1: rd = ($urandom_range(0, 31) != 0);
                    2: rd = 1'b0;
                    default: rd = $urandom_range(0, 1) != 0;
                endcase
                st = ($urandom_range(0, 19) == 0);
                xr = ($urandom_range(0, 99) == 0);
                cyc(xr, st, rd, $urandom);
            end
        end

        repeat (3) @(negedge XCLK);
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: %0d entries left, expected 0", q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/reset_sequencer.md
Name: reset_sequencer

Overview:
- Parametrised, synthesizable successor to the bench-level clock/reset/GPI fixture.
- Holds N downstream reset domains in reset, then releases them in a staggered order.
- Waits for the core's ready indication, with a timeout.
- Gates the GPI stimulus to the core until the system is running.
- Reports run/fault status and a run-cycle counter, so the MicroBlaze timers top can re-sequence itself without a testbench.

Parameters:
- NUM_RESETS, 4: number of downstream reset outputs (>=1).
- HOLD_CYCLES, 5: cycles all outputs stay in reset after sequencing starts (>=1).
- STAGGER_CYCLES, 2: cycles between successive reset releases (>=1).
- READY_TIMEOUT, 1000: max cycles to wait for ready after the last release (>=1).
- CNT_WIDTH, 16: width of the internal counters and cycle_count; all cycle parameters must fit.
- GPI_WIDTH, 32: width of the gated GPI path.

Ports:
- XCLK  in  1  system clock; all logic on the rising edge.
- XRESET  in  1  synchronous, active-high reset.
- start  in  1  re-sequence request; honoured only in RUN or FAULT.
- ready  in  1  core ready (XREADY of the core).
- gpi_in  in  GPI_WIDTH  raw GPI stimulus.
- rst_out  out  NUM_RESETS  active-high resets to the downstream domains.
- gpi_out  out  GPI_WIDTH  gated, registered GPI to the core.
- state  out  3  HOLD=0, RELEASE=1, WAIT_READY=2, RUN=3, FAULT=4.
- done  out  1  high while in RUN.
- fault  out  1  high while in FAULT.
- fault_cause  out  1  0 = ready timeout, 1 = ready lost during RUN; valid while fault=1.
- cycle_count  out  CNT_WIDTH  cycles spent in RUN; saturating.

Behaviour:
Reset and edge numbering:
- XRESET=1 at an edge forces, at that edge: state=HOLD, rst_out = all ones, gpi_out=0, done=0, fault=0, fault_cause=0, cycle_count=0, internal counters=0.
- XRESET takes priority over every other input, including mid-sequence and in RUN.
- Edge 1 is the first edge sampling XRESET=0 (or the first edge after HOLD is entered via start).

State machine:
- HOLD: rst_out all ones.
  - At edge HOLD_CYCLES: state -> RELEASE and rst_out[0] clears at that same edge.
- RELEASE: rst_out[i] clears at edge HOLD_CYCLES + i*STAGGER_CYCLES, in index order. Bits never re-assert inside RELEASE.
  - On the edge rst_out[NUM_RESETS-1] clears: state -> WAIT_READY, and the timeout counter is cleared.
  - If NUM_RESETS=1, HOLD goes directly to WAIT_READY at edge HOLD_CYCLES.
- WAIT_READY: ready is sampled from the edge after entry onward, at k = 1..READY_TIMEOUT.
  - ready=1 at the k-th sample -> RUN, done=1 at that edge.
  - No ready by sample READY_TIMEOUT -> FAULT with fault_cause=0 at that edge.
  - ready=1 on the timeout edge: RUN wins.
  - ready high before entry to WAIT_READY is ignored.
- RUN: cycle_count increments by 1 every edge after entry and saturates at 2^CNT_WIDTH-1.
  - ready sampled 0 -> FAULT with fault_cause=1.
  - start=1 -> HOLD.
  - If ready=0 and start=1 on the same edge, start wins (HOLD).
- FAULT: rst_out re-asserts to all ones at the entry edge; cycle_count is frozen.
  - start=1 -> HOLD.
  - fault and fault_cause hold until leaving FAULT.
- Entering HOLD via start: rst_out all ones, cycle_count=0, done=0, fault=0 at that edge, and the sequence restarts from edge 1.

start handling:
- start is ignored in HOLD, RELEASE and WAIT_READY; there is no queuing.

gpi_out:
- Registered each edge as (state==RUN) ? gpi_in : 0, using the state before the edge.
- It therefore stays 0 on the RUN-entry edge, carries gpi_in from the next edge onward, and returns to 0 one edge after leaving RUN.

Outputs: all outputs are registered; there are no combinational paths from input to output.

Test Plan:
- Defaults, ready tied 1: XRESET high 5 cycles then low -> rst_out = 1111 through edge 4, 1110@5, 1100@7, 1000@9, 0000@11; state=RUN, done=1@12; cycle_count=3 at edge 15.
- Ready never asserted, READY_TIMEOUT=8 -> state=WAIT_READY edges 11..18, FAULT@19, fault=1, fault_cause=0, rst_out=1111@19. Then pulse start -> HOLD, rst_out stays 1111, fault=0.
- In RUN, gpi_in=32'hA5A5_0F0F -> gpi_out=0 on the RUN-entry edge, 32'hA5A5_0F0F one edge later. Drop ready -> FAULT with fault_cause=1, gpi_out=0 the next edge.
- start pulsed during RELEASE (edge 8) -> ignored; sequence is identical to test 1. start pulsed in RUN together with ready=0 -> HOLD, not FAULT.
- XRESET asserted for 1 cycle at edge 8 (mid-RELEASE) -> rst_out=1111 and state=HOLD at that edge; the full sequence restarts with the new edge numbering.
- CNT_WIDTH=4, long RUN -> cycle_count saturates at 15 and does not wrap.
